uart_tb_tx: RTL and testbench

UART_TB_TX -- requirements
Module: uart_tb_tx

---
 rtl/uart_tb_pkg.sv | 22 ++
 rtl/uart_tb_tx_if.sv | 21 ++
 rtl/uart_tb_tx_fifo.sv | 70 +++++++
 rtl/uart_tb_tx.sv | 178 +++++++++++++++++
 tb/tb_uart_tb_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tb_pkg.sv
// Shared definitions for the UART transmitter: FSM states, frame constants
// and the parity helper.
package uart_tb_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_e;

    // Even parity is the plain XOR of the byte; odd parity inverts it.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic                 odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tb_tx_if.sv
// Byte-stream handshake into the transmitter queue (valid/ready).
interface uart_tb_tx_if;
    import uart_tb_pkg::*;

    logic [DATA_BITS-1:0] data_i;
    logic                 valid_i;
    logic                 ready_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o
    );

endinterface

// File: rtl/uart_tb_tx_fifo.sv
// Registered byte queue with no fall-through; simultaneous push and pop
// both take effect.
module uart_tb_tx_fifo
    import uart_tb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tb_tx.sv
// UART transmitter: queued bytes are serialised as start/data/parity/stop
// frames with a per-frame latched bit divisor.
module uart_tb_tx
    import uart_tb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic                 cfg_parity_en_i,
    input  logic                 cfg_parity_odd_i,
    input  logic                 cfg_stop2_i,
    uart_tb_tx_if.slave          in_if,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 word_done_o
);

    localparam int BIT_W = $clog2(DATA_BITS);

    uart_tx_state_e       state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    logic                 bit_end;
    logic                 last_stop;
    logic                 can_start;
    logic                 start_frame;

    uart_tb_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (in_if.valid_i),
        .wdata_i (in_if.data_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_if.ready_o = !fifo_full;
    assign tx_o          = tx_q;

    assign bit_end   = (cnt_q == '0);
    assign last_stop = (state_q == ST_STOP) && bit_end && (!stop2_q || stop_idx_q);
    assign can_start = cfg_en_i && !fifo_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= IDLE_LEVEL;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
        end
    end

    // Per-frame snapshot of the byte and configuration.
    always_ff @(posedge clk_i) begin
        data_q    <= data_d;
        div_q     <= div_d;
        par_en_q  <= par_en_d;
        par_bit_q <= par_bit_d;
        stop2_q   <= stop2_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        stop_idx_d  = stop_idx_q;
        data_d      = data_q;
        div_d       = div_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        start_frame = 1'b0;

        if (!bit_end) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                start_frame = can_start;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    cnt_d   = div_q;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = div_q;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d    = par_en_q ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    cnt_d      = div_q;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        cnt_d      = div_q;
                    end else if (can_start) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new frame may start from IDLE or straight out of the last stop bit.
        if (start_frame) begin
            state_d   = ST_START;
            cnt_d     = cfg_div_i;
            div_d     = cfg_div_i;
            data_d    = fifo_rdata;
            par_en_d  = cfg_parity_en_i;
            par_bit_d = parity_bit(fifo_rdata, cfg_parity_odd_i);
            stop2_d   = cfg_stop2_i;
        end
    end

    // tx is registered from the next state so the line tracks state_q exactly.
    always_comb begin
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_d[bit_d];
            ST_PARITY: tx_d = par_bit_d;
            default:   tx_d = IDLE_LEVEL;
        endcase
        fifo_pop    = start_frame;
        word_done_o = last_stop;
        busy_o      = (state_q != ST_IDLE) || !fifo_empty;
    end

endmodule

// File: tb/tb_uart_tb_tx.sv
// Self-checking bench for uart_tb_tx: a waveform-level frame model checked
// every cycle, literal frame patterns, and a behavioural serial receiver.
module tb_uart_tb_tx;

    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_en;
    logic [DW-1:0] cfg_div;
    logic          cfg_par_en;
    logic          cfg_odd;
    logic          cfg_stop2;
    logic          tx;
    logic          busy;
    logic          wd;

    uart_tb_tx_if bif ();

    uart_tb_tx #(
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_en_i         (cfg_en),
        .cfg_div_i        (cfg_div),
        .cfg_parity_en_i  (cfg_par_en),
        .cfg_parity_odd_i (cfg_odd),
        .cfg_stop2_i      (cfg_stop2),
        .in_if            (bif),
        .tx_o             (tx),
        .busy_o           (busy),
        .word_done_o      (wd)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int wd_total    = 0;
    int last_wd_cyc = 0;

    byte unsigned mq[$];
    bit           mline[$];

    logic cap_tx   [0:63];
    logic cap_wd   [0:63];
    logic cap_busy [0:63];

    byte unsigned rx_q[$];
    bit           rx_on       = 1'b0;
    int           rx_bad_stop = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A frame is the list of line levels, each repeated for one bit period.
    function automatic void build_frame(input byte unsigned b);
        int reps;
        bit lv[$];
        reps = int'(cfg_div) + 1;
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(b[i]);
        if (cfg_par_en) lv.push_back((^b) ^ cfg_odd);
        lv.push_back(1'b1);
        if (cfg_stop2) lv.push_back(1'b1);
        foreach (lv[k]) begin
            for (int r = 0; r < reps; r++) mline.push_back(lv[k]);
        end
    endfunction

    // Model advance and comparison, once per clock just after the edge.
    always @(posedge clk) begin
        bit push;
        bit etx;
        #1;
        cyc++;
        push = bif.valid_i && (mq.size() < DEPTH);
        if (rst) begin
            mq.delete();
            mline.delete();
        end else begin
            if (mline.size() > 0) void'(mline.pop_front());
            if (mline.size() == 0 && cfg_en && mq.size() > 0) build_frame(mq.pop_front());
            if (push) mq.push_back(bif.data_i);
        end
        etx = (mline.size() > 0) ? mline[0] : 1'b1;
        chk1("tx_o", tx, etx);
        chk1("word_done_o", wd, mline.size() == 1);
        chk1("busy_o", busy, (mline.size() > 0) || (mq.size() > 0));
        chk1("ready_o", bif.ready_o, mq.size() < DEPTH);
        if (wd === 1'b1) begin
            wd_total++;
            last_wd_cyc = cyc;
        end
    end

    // Serial receiver for div=15 (16 cycles per bit), sampling mid-bit.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_on && tx === 1'b0) begin
                byte unsigned r;
                r = 8'h00;
                repeat (8) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (16) @(negedge clk);
                    r[b] = tx;
                end
                repeat (16) @(negedge clk);
                if (tx !== 1'b1) rx_bad_stop++;
                rx_q.push_back(r);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_and_capture(input byte unsigned b, input int n);
        @(negedge clk);
        bif.valid_i = 1'b1;
        bif.data_i  = b;
        @(negedge clk);
        bif.valid_i = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i <= n; i++) begin
            cap_tx[i]   = tx;
            cap_wd[i]   = wd;
            cap_busy[i] = busy;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [9:0]   pat55;
        logic [11:0]  pat_even;
        logic [11:0]  pat_odd;
        byte unsigned b6[6];
        byte unsigned sent[$];
        int           k;
        int           c1;
        int           guard;
        int           base;
        int           npulse;
        bit           saw_not_ready;

        rst         = 1'b1;
        cfg_en      = 1'b1;
        cfg_div     = '0;
        cfg_par_en  = 1'b0;
        cfg_odd     = 1'b0;
        cfg_stop2   = 1'b0;
        bif.valid_i = 1'b0;
        bif.data_i  = 8'h00;
        repeat (3) @(negedge clk);
        chk1("reset_tx", tx, 1'b1);
        chk1("reset_ready", bif.ready_o, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_word_done", wd, 1'b0);
        rst = 1'b0;

        // 0x55, div=3, 8N1: ten alternating bits, four cycles each.
        cfg_div = DW'(3);
        push_and_capture(8'h55, 40);
        pat55 = 10'b1010101010;
        for (int i = 0; i < 40; i++) chk1("frame55_tx", cap_tx[i], pat55[i/4]);
        npulse = 0;
        for (int i = 0; i <= 40; i++) if (cap_wd[i] === 1'b1) npulse++;
        chk32("frame55_wd_count", npulse, 1);
        chk1("frame55_wd_cycle40", cap_wd[39], 1'b1);
        chk1("frame55_tx_after", cap_tx[40], 1'b1);
        chk1("frame55_busy_after", cap_busy[40], 1'b0);

        // 0x07, div=0, parity: 11-cycle frames, parity bit at index 9.
        cfg_div    = '0;
        cfg_par_en = 1'b1;
        cfg_odd    = 1'b0;
        pat_even   = 12'b111000001110;
        pat_odd    = 12'b110000001110;
        push_and_capture(8'h07, 11);
        for (int i = 0; i < 12; i++) chk1("par_even_tx", cap_tx[i], pat_even[i]);
        chk1("par_even_wd", cap_wd[10], 1'b1);
        chk1("par_even_busy_after", cap_busy[11], 1'b0);
        cfg_odd = 1'b1;
        push_and_capture(8'h07, 11);
        for (int i = 0; i < 12; i++) chk1("par_odd_tx", cap_tx[i], pat_odd[i]);
        chk1("par_odd_wd", cap_wd[10], 1'b1);

        // Six bytes back-to-back, div=1, 8N1: 20 cycles per frame, no gaps.
        cfg_par_en = 1'b0;
        cfg_odd    = 1'b0;
        cfg_div    = DW'(1);
        b6 = '{8'h11, 8'h22, 8'h33, 8'hC4, 8'hA5, 8'h0F};
        base = wd_total;
        k = 0;
        c1 = 0;
        guard = 0;
        saw_not_ready = 1'b0;
        while (k < 6 && guard < 500) begin
            @(negedge clk);
            guard++;
            bif.data_i  = b6[k];
            bif.valid_i = 1'b1;
            if (bif.ready_o === 1'b1) begin
                if (k == 0) c1 = cyc + 1;
                k++;
            end else begin
                saw_not_ready = 1'b1;
            end
        end
        @(negedge clk);
        bif.valid_i = 1'b0;
        guard = 0;
        while (wd_total - base < 6 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk32("b2b_frames", wd_total - base, 6);
        chk32("b2b_span", last_wd_cyc - c1, 120);
        chk1("b2b_ready_dropped", saw_not_ready, 1'b1);
        chk1("b2b_busy_in_last", busy, 1'b1);
        @(negedge clk);
        chk1("b2b_busy_after", busy, 1'b0);

        // Reset in the DATA phase of the second of three frames.
        cfg_div = DW'(2);
        base = wd_total;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bif.data_i  = 8'(8'h90 + i);
            bif.valid_i = 1'b1;
        end
        @(negedge clk);
        bif.valid_i = 1'b0;
        guard = 0;
        while (wd_total - base < 1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk1("midrst_tx", tx, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_ready", bif.ready_o, 1'b1);
        chk1("midrst_wd", wd, 1'b0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk32("midrst_no_more_wd", wd_total - base, 1);
        chk1("midrst_idle_tx", tx, 1'b1);

        // Random traffic, configuration churn and enable/reset pulses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 40) begin
                bif.valid_i = 1'b1;
                bif.data_i  = 8'($urandom);
            end else begin
                bif.valid_i = 1'b0;
            end
            if ($urandom_range(0, 99) < 3) begin
                cfg_div    = DW'($urandom_range(0, 3));
                cfg_par_en = 1'($urandom);
                cfg_odd    = 1'($urandom);
                cfg_stop2  = 1'($urandom);
            end
            if ($urandom_range(0, 99) < 2) cfg_en = ~cfg_en;
            rst = ($urandom_range(0, 999) < 2);
        end
        @(negedge clk);
        bif.valid_i = 1'b0;
        rst         = 1'b0;
        cfg_en      = 1'b1;
        guard = 0;
        while (busy !== 1'b0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk1("soak_drained", busy, 1'b0);

        // Loopback at div=15, two stop bits, 16 random bytes.
        cfg_div    = DW'(15);
        cfg_stop2  = 1'b1;
        cfg_par_en = 1'b0;
        cfg_odd    = 1'b0;
        repeat (4) @(negedge clk);
        rx_q.delete();
        rx_on = 1'b1;
        for (int i = 0; i < 16; i++) sent.push_back(8'($urandom));
        k = 0;
        guard = 0;
        while (k < 16 && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (bif.ready_o === 1'b1) begin
                bif.data_i  = sent[k];
                bif.valid_i = 1'b1;
                k++;
            end else begin
                bif.valid_i = 1'b0;
            end
        end
        @(negedge clk);
        bif.valid_i = 1'b0;
        guard = 0;
        while ((rx_q.size() < 16 || busy !== 1'b0) && guard < 6000) begin
            @(negedge clk);
            guard++;
        end
        chk32("loop_count", rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) chk32("loop_byte", int'(rx_q[i]), int'(sent[i]));

        // Dropping the enable mid-frame completes that frame only.
        base = wd_total;
        sent.push_back(8'($urandom));
        sent.push_back(8'($urandom));
        for (int i = 16; i < 18; i++) begin
            @(negedge clk);
            bif.data_i  = sent[i];
            bif.valid_i = 1'b1;
        end
        @(negedge clk);
        bif.valid_i = 1'b0;
        guard = 0;
        while (tx !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (40) @(negedge clk);
        cfg_en = 1'b0;
        repeat (500) @(negedge clk);
        chk32("en_off_rx_count", rx_q.size(), 17);
        chk32("en_off_frames", wd_total - base, 1);
        chk1("en_off_busy", busy, 1'b1);
        chk1("en_off_tx", tx, 1'b1);
        cfg_en = 1'b1;
        guard = 0;
        while ((rx_q.size() < 18 || busy !== 1'b0) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk32("en_on_rx_count", rx_q.size(), 18);
        for (int i = 16; i < 18 && i < rx_q.size(); i++) chk32("en_byte", int'(rx_q[i]), int'(sent[i]));
        chk32("loop_stop_bits", rx_bad_stop, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
